// File: rtl/ser4x1.sv
// ser4x1: one 4-word beat in, four single-word beats out, d0 first.
// Define SER4X1_REG_STALL_EN for a flop-only upstream stall (1 beat per 5 cycles).
module ser4x1 #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   output logic [1:0]   cu_sflags,
   input  logic [W-1:0] uc_d0,
   input  logic [W-1:0] uc_d1,
   input  logic [W-1:0] uc_d2,
   input  logic [W-1:0] uc_d3,
   input  logic [3:0]   uc_mflags,
   output logic [W-1:0] cd_d0,
   output logic [3:0]   cd_mflags,
   input  logic [1:0]   dc_sflags
);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t       r_state;
   state_t       w_state_nxt;
   logic [1:0]   r_cnt;
   logic [1:0]   w_cnt_nxt;
   logic [W-1:0] r_h [4];
   logic         r_sop;
   logic         r_eop;
   logic         r_err;
   logic [W-1:0] r_cd_d0;
   logic [3:0]   r_cd_mflags;
   logic [W-1:0] w_cd_d0_nxt;
   logic [3:0]   w_cd_mflags_nxt;
   logic         w_load;
   logic         w_stall;
   logic         w_out_take;
   logic         w_in_take;
   logic         w_last;
   logic         w_flush;
   logic         w_sop_nxt;
   logic         w_eop_nxt;
   logic         w_err_nxt;

   assign w_flush    = dc_sflags[1];
   assign w_last     = (r_cnt == 2'd3);
   assign w_out_take = (r_state == SHIFT) & ~dc_sflags[0];

`ifdef SER4X1_REG_STALL_EN
   logic r_stall;

   always_ff @(posedge clk) begin
      if (!rst_n) r_stall <= 1'b0;
      else        r_stall <= (w_state_nxt == SHIFT);
   end

   assign w_stall = r_stall;
`else
   // Open for a reload exactly when the last word is leaving.
   assign w_stall = (r_state == SHIFT) & ~(w_last & w_out_take);
`endif

   assign w_in_take = rst_n & uc_mflags[0] & ~w_stall;
   assign cu_sflags = rst_n ? {dc_sflags[1], w_stall} : 2'b01;

   // State register, holding words and registered outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_cnt       <= 2'd0;
         r_sop       <= 1'b0;
         r_eop       <= 1'b0;
         r_err       <= 1'b0;
         r_cd_d0     <= '0;
         r_cd_mflags <= 4'b0000;
         for (int i = 0; i < 4; i++) r_h[i] <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_cd_d0     <= w_cd_d0_nxt;
         r_cd_mflags <= w_cd_mflags_nxt;
         if (w_load) begin
            r_h[0] <= uc_d0;
            r_h[1] <= uc_d1;
            r_h[2] <= uc_d2;
            r_h[3] <= uc_d3;
            r_sop  <= uc_mflags[1];
            r_eop  <= uc_mflags[2];
            r_err  <= uc_mflags[3];
         end
      end
   end

   // Next state; flush wins over both shifting and reloading
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_load      = 1'b0;
      if (w_flush) begin
         w_state_nxt = IDLE;
         w_cnt_nxt   = 2'd0;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (w_in_take) begin
                  w_state_nxt = SHIFT;
                  w_cnt_nxt   = 2'd0;
                  w_load      = 1'b1;
               end
            end
            SHIFT: begin
               if (w_out_take) begin
                  if (!w_last) begin
                     w_cnt_nxt = r_cnt + 2'd1;
                  end else if (w_in_take) begin
                     w_cnt_nxt = 2'd0;
                     w_load    = 1'b1;
                  end else begin
                     w_state_nxt = IDLE;
                     w_cnt_nxt   = 2'd0;
                  end
               end
            end
            default: begin
               w_state_nxt = IDLE;
            end
         endcase
      end
   end

   assign w_sop_nxt = w_load ? uc_mflags[1] : r_sop;
   assign w_eop_nxt = w_load ? uc_mflags[2] : r_eop;
   assign w_err_nxt = w_load ? uc_mflags[3] : r_err;

   // Outputs are computed from next-state so word0 appears one edge after acceptance
   always_comb begin
      w_cd_d0_nxt     = '0;
      w_cd_mflags_nxt = 4'b0000;
      if (w_state_nxt == SHIFT) begin
         w_cd_d0_nxt     = w_load ? uc_d0 : r_h[w_cnt_nxt];
         w_cd_mflags_nxt = {w_err_nxt,
                            w_eop_nxt & (w_cnt_nxt == 2'd3),
                            w_sop_nxt & (w_cnt_nxt == 2'd0),
                            1'b1};
      end
   end

   assign cd_d0     = r_cd_d0;
   assign cd_mflags = r_cd_mflags;

endmodule

// File: tb/tb_ser4x1.sv
// tb_ser4x1: scenario tasks checked against a queue model of the emitted words.
// Expected throughput figures follow SER4X1_REG_STALL_EN when it is defined.
module tb_ser4x1;

   localparam int W = 32;

`ifdef SER4X1_REG_STALL_EN
   localparam int B2B_V   = 13;
   localparam int B2B_S   = 13;
   localparam int ERR_ACC = 5;
   localparam int ERR_S   = 4;
`else
   localparam int B2B_V   = 16;
   localparam int B2B_S   = 12;
   localparam int ERR_ACC = 4;
   localparam int ERR_S   = 3;
`endif

   logic         clk = 1'b0;
   logic         rst_n;
   logic [1:0]   cu_sflags;
   logic [W-1:0] uc_d0, uc_d1, uc_d2, uc_d3;
   logic [3:0]   uc_mflags;
   logic [W-1:0] cd_d0;
   logic [3:0]   cd_mflags;
   logic [1:0]   dc_sflags;

   int n_run  = 0;
   int n_fail = 0;

   logic [W-1:0] q_d [$];
   logic [3:0]   q_f [$];

   bit           t_ox, t_ix, t_have;
   logic [1:0]   t_cs;
   logic [W-1:0] t_gd, t_ed;
   logic [3:0]   t_gf, t_ef;

   ser4x1 #(.W(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cu_sflags (cu_sflags),
      .uc_d0     (uc_d0),
      .uc_d1     (uc_d1),
      .uc_d2     (uc_d2),
      .uc_d3     (uc_d3),
      .uc_mflags (uc_mflags),
      .cd_d0     (cd_d0),
      .cd_mflags (cd_mflags),
      .dc_sflags (dc_sflags)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, required finish");
      $fatal(1);
   end

   task automatic set_beat(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] c, input logic [W-1:0] d,
                           input logic [3:0] f);
      uc_d0 = a; uc_d1 = b; uc_d2 = c; uc_d3 = d;
      uc_mflags = f;
   endtask

   // One clock: observe both handshakes, advance the word-queue model.
   task automatic tick();
      logic [W-1:0] w [4];
      #1;
      t_ox = rst_n && cd_mflags[0] && !dc_sflags[0] && !dc_sflags[1];
      t_ix = rst_n && uc_mflags[0] && !cu_sflags[0];
      t_cs = cu_sflags;
      t_gd = cd_d0;
      t_gf = cd_mflags;
      t_have = 1'b0;
      t_ed = '0;
      t_ef = '0;
      if (t_ox && q_d.size() > 0) begin
         t_have = 1'b1;
         t_ed = q_d.pop_front();
         t_ef = q_f.pop_front();
      end
      if (!rst_n || dc_sflags[1]) begin
         q_d.delete();
         q_f.delete();
      end else if (t_ix) begin
         w = '{uc_d0, uc_d1, uc_d2, uc_d3};
         for (int k = 0; k < 4; k++) begin
            q_d.push_back(w[k]);
            q_f.push_back({uc_mflags[3], uc_mflags[2] && (k == 3),
                           uc_mflags[1] && (k == 0), 1'b1});
         end
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      dc_sflags = 2'b00;
      set_beat('0, '0, '0, '0, 4'b0000);
      repeat (2) @(negedge clk);
      #1;
      n_run++;
      if (cd_d0 !== '0) begin
         n_fail++;
         $display("FAIL reset_d0: got %h want 0", cd_d0);
      end
      n_run++;
      if (cd_mflags !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_mflags: got %b want 0000", cd_mflags);
      end
      n_run++;
      if (cu_sflags !== 2'b01) begin
         n_fail++;
         $display("FAIL reset_sflags: got %b want 01", cu_sflags);
      end
      dc_sflags = 2'b10;
      #1;
      n_run++;
      if (cu_sflags !== 2'b01) begin
         n_fail++;
         $display("FAIL reset_sflags_flush: got %b want 01", cu_sflags);
      end
      @(negedge clk);
      rst_n = 1'b1;
      dc_sflags = 2'b00;
      #1;
      n_run++;
      if (cu_sflags !== 2'b00 || cd_mflags !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_release: got sflags %b mflags %b want 00 0000",
                  cu_sflags, cd_mflags);
      end
   endtask

   task automatic test_single_beat();
      logic [W-1:0] ed [4];
      logic [3:0]   ef [4];
      ed = '{32'h11, 32'h22, 32'h33, 32'h44};
      ef = '{4'b0011, 4'b0001, 4'b0001, 4'b0101};
      dc_sflags = 2'b00;
      set_beat(32'h11, 32'h22, 32'h33, 32'h44, 4'b0111);
      tick();
      n_run++;
      if (!t_ix) begin
         n_fail++;
         $display("FAIL single_accept: got no transfer want transfer");
      end
      uc_mflags = 4'b0000;
      for (int k = 0; k < 4; k++) begin
         tick();
         n_run++;
         if (!t_ox || t_gd !== ed[k] || t_gf !== ef[k]) begin
            n_fail++;
            $display("FAIL single_word%0d: got v=%0d %h/%b want %h/%b",
                     k, t_ox, t_gd, t_gf, ed[k], ef[k]);
         end
      end
      #1;
      n_run++;
      if (cd_mflags !== 4'b0000 || q_d.size() != 0) begin
         n_fail++;
         $display("FAIL single_idle: got mflags %b q=%0d want 0000 q=0",
                  cd_mflags, q_d.size());
      end
   endtask

   task automatic test_back_to_back();
      int b = 0;
      int nv = 0;
      int ns = 0;
      dc_sflags = 2'b00;
      set_beat(W'(32'h10), W'(32'h11), W'(32'h12), W'(32'h13),
               {3'($urandom_range(0, 7)), 1'b1});
      for (int c = 0; c < 17; c++) begin
         tick();
         if (c > 0) begin
            nv += int'(t_ox);
            ns += int'(t_cs[0]);
         end
         if (t_ox) begin
            n_run++;
            if (!t_have || t_gd !== t_ed || t_gf !== t_ef) begin
               n_fail++;
               $display("FAIL b2b_data: got %h/%b want %h/%b",
                        t_gd, t_gf, t_ed, t_ef);
            end
         end
         if (t_ix) begin
            b++;
            set_beat(W'(32'h10 + 4 * b), W'(32'h11 + 4 * b),
                     W'(32'h12 + 4 * b), W'(32'h13 + 4 * b),
                     {3'($urandom_range(0, 7)), 1'b1});
         end
      end
      n_run++;
      if (nv != B2B_V) begin
         n_fail++;
         $display("FAIL b2b_valid_cycles: got %0d want %0d", nv, B2B_V);
      end
      n_run++;
      if (ns != B2B_S) begin
         n_fail++;
         $display("FAIL b2b_stall_cycles: got %0d want %0d", ns, B2B_S);
      end
      uc_mflags = 4'b0000;
      for (int k = 0; k < 24 && q_d.size() > 0; k++) begin
         tick();
         if (t_ox) begin
            n_run++;
            if (!t_have || t_gd !== t_ed || t_gf !== t_ef) begin
               n_fail++;
               $display("FAIL b2b_drain: got %h/%b want %h/%b",
                        t_gd, t_gf, t_ed, t_ef);
            end
         end
      end
      #1;
      n_run++;
      if (q_d.size() != 0 || cd_mflags !== 4'b0000) begin
         n_fail++;
         $display("FAIL b2b_end: got q=%0d mflags %b want q=0 0000",
                  q_d.size(), cd_mflags);
      end
   endtask

   task automatic test_backpressure();
      dc_sflags = 2'b00;
      set_beat(32'h11, 32'h22, 32'h33, 32'h44, 4'b0001);
      tick();
      uc_mflags = 4'b0000;
      tick();
      n_run++;
      if (!t_ox || !t_have || t_gd !== t_ed || t_gf !== t_ef) begin
         n_fail++;
         $display("FAIL bp_first: got %h/%b want %h/%b", t_gd, t_gf, t_ed, t_ef);
      end
      dc_sflags = 2'b01;
      for (int k = 0; k < 5; k++) begin
         tick();
         n_run++;
         if (t_gd !== 32'h22 || t_gf[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_hold%0d: got %h v=%b want 22 v=1", k, t_gd, t_gf[0]);
         end
      end
      dc_sflags = 2'b00;
      tick();
      n_run++;
      if (!t_ox || !t_have || t_gd !== t_ed || t_gf !== t_ef || t_gd !== 32'h22) begin
         n_fail++;
         $display("FAIL bp_release: got %h/%b want %h/%b", t_gd, t_gf, t_ed, t_ef);
      end
      tick();
      n_run++;
      if (!t_ox || t_gd !== 32'h33 || t_gd !== t_ed || t_gf !== t_ef) begin
         n_fail++;
         $display("FAIL bp_next: got %h/%b want 33/%b", t_gd, t_gf, t_ef);
      end
      for (int k = 0; k < 24 && q_d.size() > 0; k++) begin
         tick();
         if (t_ox) begin
            n_run++;
            if (!t_have || t_gd !== t_ed || t_gf !== t_ef) begin
               n_fail++;
               $display("FAIL bp_drain: got %h/%b want %h/%b",
                        t_gd, t_gf, t_ed, t_ef);
            end
         end
      end
      #1;
      n_run++;
      if (q_d.size() != 0 || cd_mflags !== 4'b0000) begin
         n_fail++;
         $display("FAIL bp_end: got q=%0d mflags %b want q=0 0000",
                  q_d.size(), cd_mflags);
      end
   endtask

   task automatic test_flush();
      dc_sflags = 2'b00;
      set_beat(32'hA0, 32'hA1, 32'hA2, 32'hA3, 4'b0111);
      tick();
      uc_mflags = 4'b0000;
      tick();
      set_beat(32'hB0, 32'hB1, 32'hB2, 32'hB3, 4'b0001);
      dc_sflags = 2'b10;
      #1;
      n_run++;
      if (cu_sflags[1] !== 1'b1 || cd_d0 !== 32'hA1) begin
         n_fail++;
         $display("FAIL flush_prop: got flush %b d0 %h want 1 a1", cu_sflags[1], cd_d0);
      end
      tick();
      #1;
      n_run++;
      if (cd_mflags !== 4'b0000) begin
         n_fail++;
         $display("FAIL flush_next: got %b want 0000", cd_mflags);
      end
      // flush again at the reload point, with a beat offered
      dc_sflags = 2'b00;
      set_beat(32'hC0, 32'hC1, 32'hC2, 32'hC3, 4'b0001);
      tick();
      uc_mflags = 4'b0000;
      repeat (3) tick();
      set_beat(32'hD0, 32'hD1, 32'hD2, 32'hD3, 4'b0111);
      dc_sflags = 2'b10;
      tick();
      dc_sflags = 2'b00;
      uc_mflags = 4'b0000;
      for (int k = 0; k < 5; k++) begin
         tick();
         n_run++;
         if (t_gf[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_quiet%0d: got v=%b d0 %h want v=0", k, t_gf[0], t_gd);
         end
      end
      n_run++;
      if (q_d.size() != 0) begin
         n_fail++;
         $display("FAIL flush_model: got q=%0d want 0", q_d.size());
      end
   endtask

   task automatic test_reset_mid();
      int no = 0;
      dc_sflags = 2'b00;
      set_beat($urandom, $urandom, $urandom, $urandom, 4'b0111);
      tick();
      uc_mflags = 4'b0000;
      repeat (2) tick();
      rst_n = 1'b0;
      #1;
      n_run++;
      if (cu_sflags !== 2'b01) begin
         n_fail++;
         $display("FAIL rstmid_sflags: got %b want 01", cu_sflags);
      end
      tick();
      #1;
      n_run++;
      if (cd_mflags !== 4'b0000 || cd_d0 !== '0) begin
         n_fail++;
         $display("FAIL rstmid_out: got %h/%b want 0/0000", cd_d0, cd_mflags);
      end
      rst_n = 1'b1;
      set_beat($urandom, $urandom, $urandom, $urandom, 4'b0111);
      tick();
      n_run++;
      if (!t_ix) begin
         n_fail++;
         $display("FAIL rstmid_accept: got no transfer want transfer");
      end
      uc_mflags = 4'b0000;
      for (int k = 0; k < 24 && q_d.size() > 0; k++) begin
         tick();
         if (t_ox) begin
            no++;
            n_run++;
            if (!t_have || t_gd !== t_ed || t_gf !== t_ef) begin
               n_fail++;
               $display("FAIL rstmid_drain: got %h/%b want %h/%b",
                        t_gd, t_gf, t_ed, t_ef);
            end
         end
      end
      n_run++;
      if (no != 4 || q_d.size() != 0) begin
         n_fail++;
         $display("FAIL rstmid_count: got %0d words want 4", no);
      end
   endtask

   task automatic test_err();
      int ns = 0;
      int acc = -1;
      int ne = 0;
      int no = 0;
      dc_sflags = 2'b00;
      set_beat($urandom, $urandom, $urandom, $urandom, 4'b1111);
      tick();
      set_beat($urandom, $urandom, $urandom, $urandom, 4'b0001);
      for (int c = 1; c < 10 && acc < 0; c++) begin
         tick();
         if (t_cs[0]) ns++;
         if (t_ix) acc = c;
         if (t_ox) begin
            no++;
            if (no <= 4 && t_gf[3]) ne++;
            n_run++;
            if (!t_have || t_gd !== t_ed || t_gf !== t_ef) begin
               n_fail++;
               $display("FAIL err_data: got %h/%b want %h/%b",
                        t_gd, t_gf, t_ed, t_ef);
            end
         end
      end
      n_run++;
      if (ne != 4) begin
         n_fail++;
         $display("FAIL err_flag: got %0d err sub-beats want 4", ne);
      end
      n_run++;
      if (acc != ERR_ACC || ns != ERR_S) begin
         n_fail++;
         $display("FAIL err_pacing: got accept %0d stall %0d want %0d %0d",
                  acc, ns, ERR_ACC, ERR_S);
      end
      uc_mflags = 4'b0000;
      for (int k = 0; k < 24 && q_d.size() > 0; k++) begin
         tick();
         if (t_ox) begin
            n_run++;
            if (!t_have || t_gd !== t_ed || t_gf !== t_ef) begin
               n_fail++;
               $display("FAIL err_drain: got %h/%b want %h/%b",
                        t_gd, t_gf, t_ed, t_ef);
            end
         end
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         if (!uc_mflags[0] || t_ix) begin
            if ($urandom_range(0, 2) != 0)
               set_beat($urandom, $urandom, $urandom, $urandom,
                        {3'($urandom_range(0, 7)), 1'b1});
            else
               uc_mflags = {3'($urandom_range(0, 7)), 1'b0};
         end
         dc_sflags[0] = ($urandom_range(0, 3) == 0);
         dc_sflags[1] = ($urandom_range(0, 39) == 0);
         tick();
         if (t_ox) begin
            n_run++;
            if (!t_have || t_gd !== t_ed || t_gf !== t_ef) begin
               n_fail++;
               $display("FAIL rand_data: got %h/%b want %h/%b",
                        t_gd, t_gf, t_ed, t_ef);
            end
         end
         if (!t_gf[0] && t_gf[3:1] !== 3'b000) begin
            n_run++;
            n_fail++;
            $display("FAIL rand_idle_flags: got %b want 000 when invalid", t_gf[3:1]);
         end
      end
      uc_mflags = 4'b0000;
      dc_sflags = 2'b00;
      for (int k = 0; k < 24 && q_d.size() > 0; k++) begin
         tick();
         if (t_ox) begin
            n_run++;
            if (!t_have || t_gd !== t_ed || t_gf !== t_ef) begin
               n_fail++;
               $display("FAIL rand_drain: got %h/%b want %h/%b",
                        t_gd, t_gf, t_ed, t_ef);
            end
         end
      end
      #1;
      n_run++;
      if (q_d.size() != 0 || cd_mflags !== 4'b0000) begin
         n_fail++;
         $display("FAIL rand_end: got q=%0d mflags %b want q=0 0000",
                  q_d.size(), cd_mflags);
      end
   endtask

   initial begin
      t_ix = 1'b0;
      test_reset();
      test_single_beat();
      test_back_to_back();
      test_backpressure();
      test_flush();
      test_reset_mid();
      test_err();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
